syn_fifo_ctrl: RTL and testbench
================================

SYN_FIFO_CTRL -- requirements
Module: syn_fifo_ctrl

Interface
REQ-001 The module SHALL have parameter FIFO_ENTRIES, default 1024: depth of the controlled FIFO.
REQ-002 The module SHALL have parameter DATA_WIDTH, default 16: FIFO data width.
REQ-003 The module SHALL have parameter AF_OFFSET, default 16: almost-full/almost-empty offset programmed at start-up.
REQ-004 The module SHALL have clk_i, input, 1: single clock for all logic; one clock, reset asynchronous and active-low.
REQ-005 The module SHALL have rst_n_i, input, 1: asynchronous active-low reset.
REQ-006 The module SHALL have wr_req_i, input, 2: write request, bit n from requester n.
REQ-007 The module SHALL have wr_data0_i and wr_data1_i, input, DATA_WIDTH each: write data of requester 0 and requester 1.
REQ-008 The module SHALL have wr_gnt_o, output, 2: one-hot write grant, meaning the word is accepted this cycle.
REQ-009 The module SHALL have rd_req_i, input, 1: read request.
REQ-010 The module SHALL have rd_valid_o, output, 1: rd_data_o is valid.
REQ-011 The module SHALL have rd_data_o, output, DATA_WIDTH: read data.
REQ-012 The module SHALL have wr_o, rd_o, oe_o and daf_o, output, 1 each: FIFO write, read, output-enable and define-almost-full strobes.
REQ-013 The module SHALL have data_in_o, output, DATA_WIDTH: FIFO write data bus.
REQ-014 The module SHALL have data_out_i, input, DATA_WIDTH: FIFO read data bus.
REQ-015 The module SHALL have fifo_empty_i, fifo_full_i, half_full_i and af_ae_i, input, 1 each: FIFO status flags.
REQ-016 The module SHALL have level_o, output, $clog2(FIFO_ENTRIES)+1: tracked occupancy.
REQ-017 The module SHALL have ovf_o and udf_o, output, 1 each: sticky overflow and underflow-attempt flags.
REQ-018 The module SHALL have flag_err_o, output, 1: sticky flag-consistency error.

Function
REQ-019 The state machine SHALL have states CFG, WAIT and RUN; reset enters CFG.
REQ-020 In CFG for exactly one cycle: daf_o=1 and data_in_o=AF_OFFSET; wr_o, rd_o, oe_o and grants 0; next state WAIT.
REQ-021 WAIT SHALL last exactly one cycle with all strobes 0, then go to RUN; RUN SHALL be held until reset.
REQ-022 Outside RUN, wr_gnt_o SHALL be 00, rd_o SHALL be 0 and requests SHALL be ignored.
REQ-023 Write arbitration in RUN: grant is combinational in the request cycle; a single requester is granted; when both request, the requester not granted last wins (round-robin pointer, reset value favours requester 0).
REQ-024 The round-robin pointer SHALL update only on a cycle with a nonzero grant.
REQ-025 When fifo_full_i=1, wr_gnt_o SHALL be 00 and wr_o SHALL be 0; if any wr_req_i bit is set, ovf_o SHALL set in that cycle.
REQ-026 wr_o SHALL equal |wr_gnt_o; data_in_o SHALL be the granted requester's data, else hold its last value.
REQ-027 rd_o SHALL equal rd_req_i & ~fifo_empty_i in RUN; if rd_req_i=1 with fifo_empty_i=1, udf_o SHALL set in that cycle.
REQ-028 oe_o SHALL be asserted in the cycle of rd_o and the following cycle.
REQ-029 rd_valid_o SHALL be 1 exactly one cycle after each rd_o, with rd_data_o = data_out_i registered on that edge (latency 1), else 0.
REQ-030 level_o: +1 on wr_o only, -1 on rd_o only, unchanged on simultaneous wr_o and rd_o; it SHALL saturate at 0 and FIFO_ENTRIES without wrap-around.
REQ-031 flag_err_o SHALL set when, in RUN, fifo_full_i != (level_o==FIFO_ENTRIES), fifo_empty_i != (level_o==0), or half_full_i != (level_o >= FIFO_ENTRIES/2), compared on registered flags one cycle after any level change.
REQ-032 Sticky flags ovf_o, udf_o and flag_err_o SHALL clear only on reset.

Reset
REQ-033 On rst_n_i=0 all outputs SHALL go to 0 asynchronously, level_o to 0, the pointer to requester 0, and the state to CFG.
REQ-034 Deassertion mid-operation SHALL re-run CFG then WAIT before any grant; requests pending during reset SHALL be dropped, not queued.

Verification
REQ-035 Scenario: release reset -> daf_o=1 with data_in_o=0x0010 for 1 cycle, first possible grant on cycle 3.
REQ-036 Scenario: wr_req_i=11 held for 4 cycles with data0=0xA000 and data1=0xB000 -> grants 01,10,01,10 and data_in_o A000,B000,A000,B000, ending at level_o=4.
REQ-037 Scenario: fill 1024 words, then wr_req_i=01 -> wr_o=0, ovf_o=1, level_o=1024, full flag consistent with flag_err_o=0.
REQ-038 Scenario: rd_req_i on an empty FIFO -> rd_o=0, udf_o=1; after one write of 0x1234, a read gives rd_valid_o=1 next cycle with rd_data_o=0x1234.
REQ-039 Scenario: simultaneous write and read at level 512 -> level_o stays 512 and half_full_i matches.
REQ-040 Scenario: reset asserted while wr_req_i=11 at level 7 -> outputs 0 immediately, level_o=0, and the CFG sequence repeats.

Source files
------------

// File: rtl/syn_fifo_ctrl_if.sv
// rtl/syn_fifo_ctrl_if.sv - requester, reader and FIFO-side signal bundle for syn_fifo_ctrl
// slave is the controller's view; master is the view of the logic around it.
interface syn_fifo_ctrl_if #(
  parameter int FIFO_ENTRIES = 1024,
  parameter int DATA_WIDTH   = 16
);
  localparam int LW = $clog2(FIFO_ENTRIES) + 1;

  logic [1:0]            wr_req_i;
  logic [DATA_WIDTH-1:0] wr_data0_i;
  logic [DATA_WIDTH-1:0] wr_data1_i;
  logic [1:0]            wr_gnt_o;
  logic                  rd_req_i;
  logic                  rd_valid_o;
  logic [DATA_WIDTH-1:0] rd_data_o;
  logic                  wr_o;
  logic                  rd_o;
  logic                  oe_o;
  logic                  daf_o;
  logic [DATA_WIDTH-1:0] data_in_o;
  logic [DATA_WIDTH-1:0] data_out_i;
  logic                  fifo_empty_i;
  logic                  fifo_full_i;
  logic                  half_full_i;
  logic                  af_ae_i;
  logic [LW-1:0]         level_o;
  logic                  ovf_o;
  logic                  udf_o;
  logic                  flag_err_o;

  modport slave (
    input  wr_req_i, wr_data0_i, wr_data1_i, rd_req_i, data_out_i,
           fifo_empty_i, fifo_full_i, half_full_i, af_ae_i,
    output wr_gnt_o, rd_valid_o, rd_data_o, wr_o, rd_o, oe_o, daf_o,
           data_in_o, level_o, ovf_o, udf_o, flag_err_o
  );

  modport master (
    output wr_req_i, wr_data0_i, wr_data1_i, rd_req_i, data_out_i,
           fifo_empty_i, fifo_full_i, half_full_i, af_ae_i,
    input  wr_gnt_o, rd_valid_o, rd_data_o, wr_o, rd_o, oe_o, daf_o,
           data_in_o, level_o, ovf_o, udf_o, flag_err_o
  );
endinterface

// File: rtl/syn_fifo_ctrl.sv
// rtl/syn_fifo_ctrl.sv - two-requester write arbiter and read controller for an external flagged FIFO
// Programs the almost-full offset once after reset, then tracks occupancy and cross-checks the FIFO flags.
module syn_fifo_ctrl #(
  parameter int FIFO_ENTRIES = 1024,
  parameter int DATA_WIDTH   = 16,
  parameter int AF_OFFSET    = 16
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  syn_fifo_ctrl_if.slave bus
);
  localparam int LW = $clog2(FIFO_ENTRIES) + 1;
  localparam logic [LW-1:0] LVL_MAX  = LW'(FIFO_ENTRIES);
  localparam logic [LW-1:0] LVL_HALF = LW'(FIFO_ENTRIES / 2);

  typedef enum logic [1:0] {ST_CFG, ST_WAIT, ST_RUN} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_rr_ptr;
  logic [DATA_WIDTH-1:0] r_data_hold;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_d;
  logic [LW-1:0]         r_level;
  logic                  r_ovf;
  logic                  r_udf;
  logic                  r_flag_err;
  logic                  r_chk_pend;

  logic [1:0]            w_gnt;
  logic                  w_run;
  logic                  w_daf;
  logic                  w_wr;
  logic                  w_rd;
  logic [DATA_WIDTH-1:0] w_data_in;
  logic [LW-1:0]         w_level_nxt;
  logic                  w_flag_mismatch;
  logic                  w_unused;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= ST_CFG;
    else          r_state <= w_state_nxt;
  end

  // r_rr_ptr names the requester that wins the next contested cycle
  always_comb begin
    w_state_nxt = r_state;
    w_gnt       = 2'b00;
    w_daf       = 1'b0;
    w_run       = 1'b0;
    case (r_state)
      ST_CFG: begin
        w_daf       = rst_n_i;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: w_state_nxt = ST_RUN;
      ST_RUN: begin
        w_run = 1'b1;
        if (!bus.fifo_full_i) begin
          case (bus.wr_req_i)
            2'b01:   w_gnt = 2'b01;
            2'b10:   w_gnt = 2'b10;
            2'b11:   w_gnt = r_rr_ptr ? 2'b10 : 2'b01;
            default: w_gnt = 2'b00;
          endcase
        end
      end
      default: w_state_nxt = ST_CFG;
    endcase
  end

  assign w_wr = |w_gnt;
  assign w_rd = w_run & bus.rd_req_i & ~bus.fifo_empty_i;

  always_comb begin
    w_data_in = r_data_hold;
    if (w_daf)         w_data_in = DATA_WIDTH'(AF_OFFSET);
    else if (w_gnt[1]) w_data_in = bus.wr_data1_i;
    else if (w_gnt[0]) w_data_in = bus.wr_data0_i;
  end

  always_comb begin
    w_level_nxt = r_level;
    if (w_wr && !w_rd && r_level != LVL_MAX)
      w_level_nxt = r_level + 1'b1;
    else if (w_rd && !w_wr && r_level != '0)
      w_level_nxt = r_level - 1'b1;
  end

  assign w_flag_mismatch = (bus.fifo_full_i  != (r_level == LVL_MAX)) |
                           (bus.fifo_empty_i != (r_level == '0)) |
                           (bus.half_full_i  != (r_level >= LVL_HALF));

  // flags are only trusted one cycle after the level moved, once the FIFO has caught up
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_rr_ptr    <= 1'b0;
      r_data_hold <= '0;
      r_rd_data   <= '0;
      r_rd_d      <= 1'b0;
      r_level     <= '0;
      r_ovf       <= 1'b0;
      r_udf       <= 1'b0;
      r_flag_err  <= 1'b0;
      r_chk_pend  <= 1'b0;
    end else begin
      if (w_wr) r_rr_ptr <= w_gnt[0];
      r_data_hold <= w_data_in;
      r_rd_d      <= w_rd;
      if (w_rd) r_rd_data <= bus.data_out_i;
      r_level     <= w_level_nxt;
      r_chk_pend  <= (w_level_nxt != r_level);
      if (w_run && bus.fifo_full_i && (|bus.wr_req_i))    r_ovf <= 1'b1;
      if (w_run && bus.rd_req_i && bus.fifo_empty_i)       r_udf <= 1'b1;
      if (w_run && r_chk_pend && w_flag_mismatch)          r_flag_err <= 1'b1;
    end
  end

  assign w_unused       = bus.af_ae_i;
  assign bus.wr_gnt_o   = w_gnt;
  assign bus.wr_o       = w_wr;
  assign bus.rd_o       = w_rd;
  assign bus.oe_o       = w_rd | r_rd_d;
  assign bus.daf_o      = w_daf;
  assign bus.data_in_o  = w_data_in;
  assign bus.rd_valid_o = r_rd_d;
  assign bus.rd_data_o  = r_rd_data;
  assign bus.level_o    = r_level;
  assign bus.ovf_o      = r_ovf;
  assign bus.udf_o      = r_udf;
  assign bus.flag_err_o = r_flag_err;
endmodule

// File: tb/tb_syn_fifo_ctrl.sv
// tb/tb_syn_fifo_ctrl.sv - directed vectors for syn_fifo_ctrl against a behavioural flagged FIFO
module tb_syn_fifo_ctrl;
  localparam int DEPTH = 1024;
  localparam int DW    = 16;
  localparam int LW    = 11;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  syn_fifo_ctrl_if #(.FIFO_ENTRIES(DEPTH), .DATA_WIDTH(DW)) u_if ();

  syn_fifo_ctrl #(.FIFO_ENTRIES(DEPTH), .DATA_WIDTH(DW), .AF_OFFSET(16)) u_dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (u_if.slave)
  );

  logic [DW-1:0] m_mem [0:DEPTH-1];
  logic [9:0]    m_wp;
  logic [9:0]    m_rp;
  logic [LW-1:0] m_cnt;
  logic          m_hf_flip;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_wp  <= '0;
      m_rp  <= '0;
      m_cnt <= '0;
    end else begin
      if (u_if.wr_o) begin
        m_mem[m_wp] <= u_if.data_in_o;
        m_wp        <= m_wp + 10'd1;
      end
      if (u_if.rd_o) m_rp <= m_rp + 10'd1;
      m_cnt <= m_cnt + LW'(u_if.wr_o) - LW'(u_if.rd_o);
    end
  end

  assign u_if.data_out_i   = m_mem[m_rp];
  assign u_if.fifo_full_i  = (m_cnt == LW'(DEPTH));
  assign u_if.fifo_empty_i = (m_cnt == '0);
  assign u_if.half_full_i  = (m_cnt >= LW'(DEPTH / 2)) ^ m_hf_flip;
  assign u_if.af_ae_i      = (m_cnt <= LW'(16)) | (m_cnt >= LW'(DEPTH - 16));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_vec++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, want);
    end
  endtask

  task automatic drive(input logic [1:0] req, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                       input logic rd);
    @(negedge clk);
    u_if.wr_req_i   = req;
    u_if.wr_data0_i = d0;
    u_if.wr_data1_i = d1;
    u_if.rd_req_i   = rd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n           = 1'b0;
    m_hf_flip       = 1'b0;
    u_if.wr_req_i   = 2'b00;
    u_if.wr_data0_i = '0;
    u_if.wr_data1_i = '0;
    u_if.rd_req_i   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_daf",   32'(u_if.daf_o), 0);
    chk("rst_din",   32'(u_if.data_in_o), 0);
    chk("rst_level", 32'(u_if.level_o), 0);
    chk("rst_flags", 32'({u_if.ovf_o, u_if.udf_o, u_if.flag_err_o, u_if.rd_valid_o, u_if.oe_o}), 0);

    // CFG, WAIT, then first grant; requester 1 so the pointer still favours requester 0
    @(negedge clk);
    rst_n           = 1'b1;
    u_if.wr_req_i   = 2'b10;
    u_if.wr_data1_i = 16'h5555;
    #1;
    chk("cfg_daf", 32'(u_if.daf_o), 1);
    chk("cfg_din", 32'(u_if.data_in_o), 'h0010);
    chk("cfg_gnt", 32'({u_if.wr_gnt_o, u_if.wr_o, u_if.rd_o, u_if.oe_o}), 0);
    tick();
    @(negedge clk); #1;
    chk("wait_daf", 32'(u_if.daf_o), 0);
    chk("wait_gnt", 32'({u_if.wr_gnt_o, u_if.wr_o}), 0);
    tick();
    @(negedge clk); #1;
    chk("run_gnt", 32'(u_if.wr_gnt_o), 2);
    chk("run_wr",  32'(u_if.wr_o), 1);
    chk("run_din", 32'(u_if.data_in_o), 'h5555);
    tick();
    chk("lvl1", 32'(u_if.level_o), 1);

    drive(2'b00, 16'h0, 16'h0, 1'b1);
    chk("rd_o",  32'(u_if.rd_o), 1);
    chk("oe_rd", 32'(u_if.oe_o), 1);
    tick();
    chk("rv1",    32'(u_if.rd_valid_o), 1);
    chk("rdat1",  32'(u_if.rd_data_o), 'h5555);
    chk("oe_nxt", 32'(u_if.oe_o), 1);
    chk("lvl0",   32'(u_if.level_o), 0);
    @(negedge clk); #1;
    chk("rd_empty", 32'(u_if.rd_o), 0);
    chk("udf_pre",  32'(u_if.udf_o), 0);
    tick();
    chk("udf_set", 32'(u_if.udf_o), 1);
    chk("rv_low",  32'(u_if.rd_valid_o), 0);
    chk("oe_low",  32'(u_if.oe_o), 0);

    drive(2'b10, 16'h0, 16'h1234, 1'b0);
    chk("w1234_gnt", 32'(u_if.wr_gnt_o), 2);
    tick();
    drive(2'b00, 16'h0, 16'h0, 1'b1);
    tick();
    chk("rv_1234",   32'(u_if.rd_valid_o), 1);
    chk("rdat_1234", 32'(u_if.rd_data_o), 'h1234);

    // contested writes alternate starting with requester 0
    for (int i = 0; i < 4; i++) begin
      drive(2'b11, 16'hA000, 16'hB000, 1'b0);
      chk($sformatf("rr_gnt%0d", i), 32'(u_if.wr_gnt_o), (i % 2 == 0) ? 1 : 2);
      chk($sformatf("rr_din%0d", i), 32'(u_if.data_in_o), (i % 2 == 0) ? 'hA000 : 'hB000);
      tick();
    end
    chk("rr_lvl", 32'(u_if.level_o), 4);

    for (int i = 0; i < DEPTH - 4; i++) begin
      drive(2'b01, 16'(i), 16'h0, 1'b0);
      tick();
    end
    chk("full_lvl",  32'(u_if.level_o), DEPTH);
    chk("full_flag", 32'(u_if.fifo_full_i), 1);
    drive(2'b01, 16'hDEAD, 16'h0, 1'b0);
    chk("full_gnt", 32'({u_if.wr_gnt_o, u_if.wr_o}), 0);
    tick();
    chk("ovf_set",   32'(u_if.ovf_o), 1);
    chk("ovf_lvl",   32'(u_if.level_o), DEPTH);
    chk("full_ferr", 32'(u_if.flag_err_o), 0);

    drive(2'b01, 16'hBEEF, 16'h0, 1'b1);
    chk("full_wr_rd", 32'({u_if.wr_o, u_if.rd_o}), 1);
    tick();
    chk("full_rd_lvl", 32'(u_if.level_o), DEPTH - 1);
    chk("full_rd_dat", 32'(u_if.rd_data_o), 'hA000);
    for (int i = 0; i < 511; i++) begin
      drive(2'b00, 16'h0, 16'h0, 1'b1);
      tick();
    end
    chk("half_lvl", 32'(u_if.level_o), 512);

    drive(2'b01, 16'h7777, 16'h0, 1'b1);
    chk("sim_wr_rd", 32'({u_if.wr_o, u_if.rd_o}), 3);
    tick();
    chk("sim_lvl",  32'(u_if.level_o), 512);
    chk("sim_half", 32'(u_if.half_full_i), 1);
    drive(2'b00, 16'h0, 16'h0, 1'b0);
    tick();
    chk("sim_ferr", 32'(u_if.flag_err_o), 0);

    for (int i = 0; i < 505; i++) begin
      drive(2'b00, 16'h0, 16'h0, 1'b1);
      tick();
    end
    chk("lvl7",      32'(u_if.level_o), 7);
    chk("lvl7_ferr", 32'(u_if.flag_err_o), 0);
    @(negedge clk);
    u_if.rd_req_i = 1'b0;
    m_hf_flip     = 1'b1;
    tick();
    chk("ferr_set", 32'(u_if.flag_err_o), 1);
    m_hf_flip = 1'b0;

    // reset while both requesters are asking; nothing may carry over
    drive(2'b11, 16'h1111, 16'h2222, 1'b0);
    chk("pre_rst_gnt", 32'(u_if.wr_gnt_o), 2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_gnt",   32'({u_if.wr_gnt_o, u_if.wr_o, u_if.rd_o, u_if.oe_o, u_if.daf_o}), 0);
    chk("arst_lvl",   32'(u_if.level_o), 0);
    chk("arst_stky",  32'({u_if.ovf_o, u_if.udf_o, u_if.flag_err_o}), 0);
    chk("arst_din",   32'(u_if.data_in_o), 0);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("re_cfg_daf", 32'(u_if.daf_o), 1);
    chk("re_cfg_gnt", 32'(u_if.wr_gnt_o), 0);
    tick();
    @(negedge clk); #1;
    chk("re_wait_gnt", 32'(u_if.wr_gnt_o), 0);
    tick();
    @(negedge clk); #1;
    chk("re_run_gnt", 32'(u_if.wr_gnt_o), 1);
    chk("re_run_din", 32'(u_if.data_in_o), 'h1111);
    tick();
    chk("re_lvl", 32'(u_if.level_o), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
